// File: rtl/button_debounce_multi.sv
// button_debounce_multi: N-channel button synchroniser, debouncer and press/release/long/repeat pulse generator
module button_debounce_multi #(
  parameter int unsigned      N_CH            = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned      HOLD_CYCLES     = 50_000_000,
  parameter int unsigned      REPEAT_CYCLES   = 10_000_000,
  parameter bit               REPEAT_EN       = 1'b1,
  parameter logic [N_CH-1:0]  ACTIVE_LOW      = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_raw,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_rel,
  output logic [N_CH-1:0] btn_long,
  output logic [N_CH-1:0] btn_rpt
);
  localparam int unsigned DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW   = $clog2(HMAX + 1);
  localparam logic [DW-1:0] D_TC = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_TC = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_TC = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [N_CH-1:0] sync1_q, sync2_q;

  // two-flop synchroniser with per-channel polarity correction ahead of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw ^ ACTIVE_LOW;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    state_t        st_q, st_d;
    logic          level_q, level_d, press_q, rel_q, long_q, long_d, rpt_q, rpt_d;
    logic          rise, fall;

    // debounce: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
      level_d = level_q;
      dcnt_d  = '0;
      if (sync2_q[g] != level_q) begin
        if (dcnt_q == D_TC) level_d = ~level_q;
        else                dcnt_d  = dcnt_q + 1'b1;
      end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    // hold/repeat FSM; a release wins over a terminal count landing in the same cycle
    always_comb begin
      st_d   = st_q;
      hcnt_d = hcnt_q;
      long_d = 1'b0;
      rpt_d  = 1'b0;
      if (fall) begin
        st_d   = IDLE;
        hcnt_d = '0;
      end else begin
        case (st_q)
          IDLE: if (rise) begin
            st_d   = PRESSED;
            hcnt_d = '0;
          end
          PRESSED: if (hcnt_q == H_TC) begin
            long_d = 1'b1;
            st_d   = HELD;
            hcnt_d = '0;
          end else hcnt_d = hcnt_q + 1'b1;
          HELD: if (!REPEAT_EN) hcnt_d = '0;
          else if (hcnt_q == R_TC) begin
            rpt_d  = 1'b1;
            hcnt_d = '0;
          end else hcnt_d = hcnt_q + 1'b1;
          default: begin
            st_d   = IDLE;
            hcnt_d = '0;
          end
        endcase
      end
    end

    // per-channel state, counters and registered pulse outputs
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        st_q    <= IDLE;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        st_q    <= st_d;
        level_q <= level_d;
        press_q <= rise;
        rel_q   <= fall;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
      end
    end

    assign btn_level[g] = level_q;
    assign btn_press[g] = press_q;
    assign btn_rel[g]   = rel_q;
    assign btn_long[g]  = long_q;
    assign btn_rpt[g]   = rpt_q;
  end
endmodule

// File: tb/tb_button_debounce_multi.sv
// tb_button_debounce_multi: scenario and randomised checks of button_debounce_multi against a timing-rule model
module tb_button_debounce_multi;
  localparam int         N    = 2;
  localparam int         DEB  = 4;
  localparam int         HOLD = 16;
  localparam int         REP  = 8;
  localparam bit         REN  = 1'b1;
  localparam logic [1:0] AL   = 2'b00;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] btn_raw = 2'b00;
  logic [1:0] btn_level, btn_press, btn_rel, btn_long, btn_rpt;
  logic [9:0] act;
  int passed = 0;
  int total = 0;
  int cyc = 0;

  logic [1:0] m_h0, m_h1, m_lvl;
  int         m_run [2];
  int         m_age [2];
  logic [9:0] exp_v;

  button_debounce_multi #(
    .N_CH(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP),
    .REPEAT_EN(REN), .ACTIVE_LOW(AL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .btn_level(btn_level), .btn_press(btn_press),
    .btn_rel(btn_rel), .btn_long(btn_long), .btn_rpt(btn_rpt)
  );

  assign act = {btn_level, btn_press, btn_rel, btn_long, btn_rpt};

  always #5 clk = ~clk;

  task automatic model_reset;
    m_h0 = '0;
    m_h1 = '0;
    m_lvl = '0;
    m_run = '{0, 0};
    m_age = '{0, 0};
    exp_v = '0;
  endtask

  // level flips after DEB consecutive disagreeing synchronised samples; long/rpt by age since press
  task automatic model_step(input logic [1:0] r);
    logic [1:0] ep, er, el, eq;
    logic nl;
    ep = '0; er = '0; el = '0; eq = '0;
    for (int ch = 0; ch < N; ch++) begin
      nl = m_lvl[ch];
      if (m_h1[ch] != m_lvl[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == DEB) begin
          nl = ~nl;
          m_run[ch] = 0;
        end
      end else m_run[ch] = 0;
      ep[ch] = nl & ~m_lvl[ch];
      er[ch] = ~nl & m_lvl[ch];
      if (ep[ch]) m_age[ch] = 0;
      else if (nl) begin
        m_age[ch]++;
        el[ch] = (m_age[ch] == HOLD);
        eq[ch] = REN && (m_age[ch] > HOLD) && ((m_age[ch] - HOLD) % REP == 0);
      end
      m_lvl[ch] = nl;
    end
    m_h1 = m_h0;
    m_h0 = r ^ AL;
    exp_v = {m_lvl, ep, er, el, eq};
  endtask

  task automatic tick(input logic [1:0] r);
    btn_raw = r;
    @(posedge clk);
    if (rst_n) model_step(r);
    cyc++;
    #1;
  endtask

  task automatic test_reset;
    int c, p0, p1;
    #2 rst_n = 1'b0;
    btn_raw = 2'b11;
    model_reset();
    #1;
    total++; if (act !== 10'b0) $display("FAIL reset_immediate got=%b want=%b", act, 10'b0); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick(2'b11);
      total++; if (act !== 10'b0) $display("FAIL reset_hold cyc=%0d got=%b want=%b", cyc, act, 10'b0); else passed++;
    end
    rst_n = 1'b1;
    c = cyc; p0 = -1; p1 = -1;
    for (int i = 0; i < 10; i++) begin
      tick(2'b11);
      total++; if (act !== exp_v) $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_press[0]) p0 = cyc;
      if (btn_press[1]) p1 = cyc;
    end
    total++; if (p0 != c + 6) $display("FAIL reset_press0_time got=%0d want=%0d", p0 - c, 6); else passed++;
    total++; if (p1 != c + 6) $display("FAIL reset_press1_time got=%0d want=%0d", p1 - c, 6); else passed++;
  endtask

  task automatic test_glitch;
    int hi, lo;
    for (int i = 0; i < 10; i++) begin
      tick(2'b00);
      total++; if (act !== exp_v) $display("FAIL glitch_prep cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
    end
    for (int k = 0; k < 5; k++) begin
      hi = $urandom_range(1, DEB - 1);
      lo = $urandom_range(1, 3);
      for (int i = 0; i < hi + lo; i++) begin
        tick(i < hi ? 2'b01 : 2'b00);
        total++; if (act !== exp_v) $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
        total++; if (act !== 10'b0) $display("FAIL glitch_quiet cyc=%0d got=%b want=%b", cyc, act, 10'b0); else passed++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(2'b00);
      total++; if (act !== 10'b0) $display("FAIL glitch_tail cyc=%0d got=%b want=%b", cyc, act, 10'b0); else passed++;
    end
  endtask

  task automatic test_clean_press;
    int c, r, p_at, l_at, rel_at, rn, n_rpt;
    int ra [3];
    c = cyc; p_at = -1; l_at = -1; rn = 0; ra = '{-1, -1, -1};
    for (int i = 0; i < 47; i++) begin
      tick(2'b01);
      total++; if (act !== exp_v) $display("FAIL clean_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_press[0]) p_at = cyc;
      if (btn_long[0]) l_at = cyc;
      if (btn_rpt[0]) begin
        if (rn < 3) ra[rn] = cyc;
        rn++;
      end
    end
    total++; if (p_at != c + 6) $display("FAIL clean_press_time got=%0d want=%0d", p_at - c, 6); else passed++;
    total++; if (l_at != c + 22) $display("FAIL clean_long_time got=%0d want=%0d", l_at - c, 22); else passed++;
    total++; if (rn != 3) $display("FAIL clean_rpt_count got=%0d want=%0d", rn, 3); else passed++;
    for (int k = 0; k < 3; k++) begin
      total++; if (ra[k] != c + 30 + 8 * k) $display("FAIL clean_rpt%0d_time got=%0d want=%0d", k, ra[k] - c, 30 + 8 * k); else passed++;
    end
    r = cyc; rel_at = -1; n_rpt = 0;
    for (int i = 0; i < 20; i++) begin
      tick(2'b00);
      total++; if (act !== exp_v) $display("FAIL clean_rel_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_rel[0]) rel_at = cyc;
      if (btn_rpt[0]) n_rpt++;
    end
    total++; if (rel_at != r + 6) $display("FAIL clean_rel_time got=%0d want=%0d", rel_at - r, 6); else passed++;
    total++; if (n_rpt != 0) $display("FAIL clean_rpt_after_rel got=%0d want=%0d", n_rpt, 0); else passed++;
  endtask

  task automatic test_collision;
    int c, l_at, rel_at, rn, r0;
    c = cyc; l_at = -1; rel_at = -1; rn = 0; r0 = -1;
    for (int i = 0; i < 48; i++) begin
      tick(i < 32 ? 2'b01 : 2'b00);
      total++; if (act !== exp_v) $display("FAIL collide_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_long[0]) l_at = cyc;
      if (btn_rel[0]) rel_at = cyc;
      if (btn_rpt[0]) begin
        if (rn == 0) r0 = cyc;
        rn++;
      end
    end
    total++; if (l_at != c + 22) $display("FAIL collide_long_time got=%0d want=%0d", l_at - c, 22); else passed++;
    total++; if (rel_at != c + 38) $display("FAIL collide_rel_time got=%0d want=%0d", rel_at - c, 38); else passed++;
    total++; if (rn != 1 || r0 != c + 30) $display("FAIL collide_rpt got=%0d@%0d want=1@%0d", rn, r0 - c, 30); else passed++;
    c = cyc; l_at = -1; rn = 0;
    for (int i = 0; i < 36; i++) begin
      tick(i < 24 ? 2'b01 : 2'b00);
      total++; if (act !== exp_v) $display("FAIL collide_repress_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_long[0]) l_at = cyc;
      if (btn_rpt[0]) rn++;
    end
    total++; if (l_at != c + 22) $display("FAIL collide_repress_long got=%0d want=%0d", l_at - c, 22); else passed++;
    total++; if (rn != 0) $display("FAIL collide_repress_rpt got=%0d want=%0d", rn, 0); else passed++;
  endtask

  task automatic test_independence;
    int c, l0, rn0, p1, r1, x1;
    int ra [3];
    logic [1:0] r;
    c = cyc; l0 = -1; rn0 = 0; p1 = -1; r1 = -1; x1 = 0; ra = '{-1, -1, -1};
    for (int i = 0; i < 50; i++) begin
      r = {(i >= 10 && i < 18), 1'b1};
      tick(r);
      total++; if (act !== exp_v) $display("FAIL indep_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_long[0]) l0 = cyc;
      if (btn_rpt[0]) begin
        if (rn0 < 3) ra[rn0] = cyc;
        rn0++;
      end
      if (btn_press[1]) p1 = cyc;
      if (btn_rel[1]) r1 = cyc;
      if (btn_long[1] || btn_rpt[1]) x1++;
    end
    total++; if (l0 != c + 22) $display("FAIL indep_long0 got=%0d want=%0d", l0 - c, 22); else passed++;
    total++; if (rn0 != 3 || ra[0] != c + 30 || ra[1] != c + 38 || ra[2] != c + 46)
      $display("FAIL indep_rpt0 got=%0d:%0d,%0d,%0d want=3:30,38,46", rn0, ra[0] - c, ra[1] - c, ra[2] - c); else passed++;
    total++; if (p1 != c + 16) $display("FAIL indep_press1 got=%0d want=%0d", p1 - c, 16); else passed++;
    total++; if (r1 != c + 24) $display("FAIL indep_rel1 got=%0d want=%0d", r1 - c, 24); else passed++;
    total++; if (x1 != 0) $display("FAIL indep_ch1_extra got=%0d want=%0d", x1, 0); else passed++;
    for (int i = 0; i < 12; i++) begin
      tick(2'b00);
      total++; if (act !== exp_v) $display("FAIL indep_tail cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
    end
  endtask

  task automatic test_midreset;
    int c, p_at, l_at;
    for (int i = 0; i < 26; i++) begin
      tick(2'b01);
      total++; if (act !== exp_v) $display("FAIL midrst_pre cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (act !== 10'b0) $display("FAIL midrst_immediate got=%b want=%b", act, 10'b0); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick(2'b01);
      total++; if (act !== 10'b0) $display("FAIL midrst_hold cyc=%0d got=%b want=%b", cyc, act, 10'b0); else passed++;
    end
    rst_n = 1'b1;
    c = cyc; p_at = -1; l_at = -1;
    for (int i = 0; i < 28; i++) begin
      tick(2'b01);
      total++; if (act !== exp_v) $display("FAIL midrst_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
      if (btn_press[0]) p_at = cyc;
      if (btn_long[0]) l_at = cyc;
    end
    total++; if (p_at != c + 6) $display("FAIL midrst_press got=%0d want=%0d", p_at - c, 6); else passed++;
    total++; if (l_at != c + 22) $display("FAIL midrst_long got=%0d want=%0d", l_at - c, 22); else passed++;
    for (int i = 0; i < 12; i++) begin
      tick(2'b00);
      total++; if (act !== exp_v) $display("FAIL midrst_tail cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
    end
  endtask

  task automatic test_random;
    logic [1:0] r;
    int rem [2];
    r = btn_raw;
    rem = '{0, 0};
    for (int i = 0; i < 1500; i++) begin
      for (int ch = 0; ch < N; ch++) begin
        if (rem[ch] == 0) begin
          r[ch] = ~r[ch];
          rem[ch] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 60);
        end
        rem[ch]--;
      end
      tick(r);
      total++; if (act !== exp_v) $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, act, exp_v); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_clean_press();
    test_collision();
    test_independence();
    test_midreset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
